// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-pin bundle around sram_arbiter.
// slave = the arbiter's view; master = requesters and board SRAM.
interface sram_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;

  logic        vid_req;
  logic [18:0] vid_addr;
  logic [15:0] vid_rdata;
  logic        vid_ack;

  logic [18:0] sram_a;
  logic [15:0] sram_dout;
  logic        sram_doe;
  logic [15:0] sram_din;
  logic        sram_wel;
  logic        sram_lbl;
  logic        sram_ubl;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, sram_din,
    output cpu_rdata, cpu_ack, vid_rdata, vid_ack,
    output sram_a, sram_dout, sram_doe, sram_wel, sram_lbl, sram_ubl
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, sram_din,
    input  cpu_rdata, cpu_ack, vid_rdata, vid_ack,
    input  sram_a, sram_dout, sram_doe, sram_wel, sram_lbl, sram_ubl
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one async SRAM between a byte-wide CPU port and a word-wide video read port.
// Request-to-ack latency WAIT_STATES+2 cycles; the losing port simply keeps req high until it is served.
module sram_arbiter #(
  parameter int unsigned WAIT_STATES = 1,
  parameter bit          VIDEO_FIRST = 1'b1
) (
  input logic           clk,
  input logic           n_reset,
  sram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic        gnt_vid_q, gnt_vid_d;
  logic        we_q, we_d;
  logic [18:0] word_q, word_d;
  logic        lane_q, lane_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        last_vid_q, last_vid_d;

  logic [18:0] sram_a_q, sram_a_d;
  logic [15:0] sram_dout_q, sram_dout_d;
  logic        sram_doe_q, sram_doe_d;
  logic        sram_wel_q, sram_wel_d;
  logic        sram_lbl_q, sram_lbl_d;
  logic        sram_ubl_q, sram_ubl_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        vid_ack_q, vid_ack_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [15:0] vid_rdata_q, vid_rdata_d;

  logic        take_vid;

  // Video wins unless the CPU also asks and video had the previous grant.
  assign take_vid = bus.vid_req && (!bus.cpu_req || !last_vid_q);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    gnt_vid_d   = gnt_vid_q;
    we_d        = we_q;
    word_d      = word_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    last_vid_d  = last_vid_q;
    sram_a_d    = sram_a_q;
    sram_dout_d = sram_dout_q;
    sram_doe_d  = sram_doe_q;
    sram_wel_d  = 1'b1;
    sram_lbl_d  = 1'b1;
    sram_ubl_d  = 1'b1;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.vid_req) begin
          gnt_vid_d = take_vid;
          we_d      = !take_vid && bus.cpu_we;
          word_d    = take_vid ? bus.vid_addr : bus.cpu_addr[19:1];
          lane_d    = bus.cpu_addr[0];
          wdata_d   = bus.cpu_wdata;
          wait_d    = 3'(WAIT_STATES);
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_q == 3'd0) begin
          state_d = RECOVER;
          if (gnt_vid_q) begin
            vid_ack_d   = 1'b1;
            vid_rdata_d = bus.sram_din;
          end else begin
            cpu_ack_d = 1'b1;
            if (!we_q) cpu_rdata_d = lane_q ? bus.sram_din[15:8] : bus.sram_din[7:0];
          end
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      RECOVER: begin
        last_vid_d = gnt_vid_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes follow the next state so they come straight out of flops.
    // RECOVER keeps address and doe from ACCESS for write hold time.
    if (state_d == ACCESS) begin
      sram_a_d = word_d;
      if (we_d) begin
        sram_wel_d  = 1'b0;
        sram_lbl_d  = lane_d;
        sram_ubl_d  = !lane_d;
        sram_doe_d  = 1'b1;
        sram_dout_d = {wdata_d, wdata_d};
      end else begin
        sram_lbl_d = 1'b0;
        sram_ubl_d = 1'b0;
        sram_doe_d = 1'b0;
      end
    end else if (state_d == IDLE) begin
      sram_doe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      wait_q      <= 3'd0;
      gnt_vid_q   <= 1'b0;
      we_q        <= 1'b0;
      word_q      <= 19'd0;
      lane_q      <= 1'b0;
      wdata_q     <= 8'd0;
      last_vid_q  <= !VIDEO_FIRST;
      sram_a_q    <= 19'd0;
      sram_dout_q <= 16'd0;
      sram_doe_q  <= 1'b0;
      sram_wel_q  <= 1'b1;
      sram_lbl_q  <= 1'b1;
      sram_ubl_q  <= 1'b1;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'd0;
      vid_rdata_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      gnt_vid_q   <= gnt_vid_d;
      we_q        <= we_d;
      word_q      <= word_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      last_vid_q  <= last_vid_d;
      sram_a_q    <= sram_a_d;
      sram_dout_q <= sram_dout_d;
      sram_doe_q  <= sram_doe_d;
      sram_wel_q  <= sram_wel_d;
      sram_lbl_q  <= sram_lbl_d;
      sram_ubl_q  <= sram_ubl_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  assign bus.sram_a    = sram_a_q;
  assign bus.sram_dout = sram_dout_q;
  assign bus.sram_doe  = sram_doe_q;
  assign bus.sram_wel  = sram_wel_q;
  assign bus.sram_lbl  = sram_lbl_q;
  assign bus.sram_ubl  = sram_ubl_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.vid_ack   = vid_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.vid_rdata = vid_rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: four instances (WS=1/VF=1, WS=1/VF=0, WS=0, WS=7), each with a small SRAM model,
// checked every cycle against a transaction-level model plus directed literal expectations.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int NCFG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NCFG-1:0]       rst_n;
  logic [NCFG-1:0]       cpu_req, cpu_we, vid_req;
  logic [NCFG-1:0][19:0] cpu_addr;
  logic [NCFG-1:0][7:0]  cpu_wdata;
  logic [NCFG-1:0][18:0] vid_addr;

  logic [NCFG-1:0]       cpu_ack_o, vid_ack_o, doe_o, wel_o, lbl_o, ubl_o;
  logic [NCFG-1:0][7:0]  cpu_rdata_o;
  logic [NCFG-1:0][15:0] vid_rdata_o, dout_o;
  logic [NCFG-1:0][18:0] sram_a_o;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int ws_of(input int g);
    return (g == 2) ? 0 : ((g == 3) ? 7 : 1);
  endfunction

  function automatic logic [15:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return (b == 8'h34) ? 16'hBEEF : {b ^ 8'h5C, b};
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    sram_arbiter_if bus ();
    logic [15:0] mem [256];

    assign bus.cpu_req   = cpu_req[g];
    assign bus.cpu_we    = cpu_we[g];
    assign bus.cpu_addr  = cpu_addr[g];
    assign bus.cpu_wdata = cpu_wdata[g];
    assign bus.vid_req   = vid_req[g];
    assign bus.vid_addr  = vid_addr[g];
    assign bus.sram_din  = mem[bus.sram_a[7:0]];

    assign cpu_ack_o[g]   = bus.cpu_ack;
    assign vid_ack_o[g]   = bus.vid_ack;
    assign cpu_rdata_o[g] = bus.cpu_rdata;
    assign vid_rdata_o[g] = bus.vid_rdata;
    assign sram_a_o[g]    = bus.sram_a;
    assign dout_o[g]      = bus.sram_dout;
    assign doe_o[g]       = bus.sram_doe;
    assign wel_o[g]       = bus.sram_wel;
    assign lbl_o[g]       = bus.sram_lbl;
    assign ubl_o[g]       = bus.sram_ubl;

    sram_arbiter #(
      .WAIT_STATES (ws_of(g)),
      .VIDEO_FIRST ((g == 1) ? 1'b0 : 1'b1)
    ) dut (
      .clk     (clk),
      .n_reset (rst_n[g]),
      .bus     (bus)
    );

    // Async SRAM: write any enabled lane at each edge that sees WE low.
    initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      forever begin
        @(posedge clk);
        if (!bus.sram_wel) begin
          if (!bus.sram_lbl) mem[bus.sram_a[7:0]][7:0]  = bus.sram_dout[7:0];
          if (!bus.sram_ubl) mem[bus.sram_a[7:0]][15:8] = bus.sram_dout[15:8];
        end
      end
    end
  end

  task automatic check(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d cyc%0d %s: got 0x%0h required 0x%0h", g, cyc, nm, act, exp);
    end
  endtask

  // Transaction model: one access in flight; grant at cycle t puts ACCESS on t+1..t+WS+1,
  // the ack on t+WS+2, and the arbiter is free to grant again from t+WS+3.
  int          free_at [NCFG];
  bit          act     [NCFG];
  bit          a_vid   [NCFG];
  bit          a_we    [NCFG];
  logic [19:0] a_addr  [NCFG];
  logic [7:0]  a_dat   [NCFG];
  int          a_t     [NCFG];
  bit          pref_vid[NCFG];
  logic [7:0]  e_cr    [NCFG];
  logic [15:0] e_vr    [NCFG];
  logic [15:0] mm      [NCFG][256];

  task automatic model_step(input int g);
    int          c, ws;
    bit          e_wel, e_lbl, e_ubl, e_cack, e_vack, gv;
    logic [18:0] w;
    logic        ln;
    logic [15:0] rd;
    c = cyc; ws = ws_of(g);
    e_wel = 1; e_lbl = 1; e_ubl = 1; e_cack = 0; e_vack = 0;
    w = a_addr[g][19:1]; ln = a_addr[g][0];
    if (!rst_n[g]) begin
      act[g] = 0; free_at[g] = c + 1; pref_vid[g] = (g != 1);
      e_cr[g] = 8'h00; e_vr[g] = 16'h0000;
      check(g, "rst_sram_a", sram_a_o[g], 0);
      check(g, "rst_doe", doe_o[g], 0);
      check(g, "rst_dout", dout_o[g], 0);
    end else if (act[g]) begin
      if (c > a_t[g] && c <= a_t[g] + ws + 1) begin
        check(g, "acc_sram_a", sram_a_o[g], w);
        if (a_we[g]) begin
          e_wel = 0; e_lbl = ln; e_ubl = !ln;
          check(g, "acc_doe", doe_o[g], 1);
          check(g, "acc_dout", dout_o[g], {a_dat[g], a_dat[g]});
        end else begin
          e_lbl = 0; e_ubl = 0;
          check(g, "acc_doe", doe_o[g], 0);
        end
      end else if (c == a_t[g] + ws + 2) begin
        check(g, "rec_sram_a", sram_a_o[g], w);
        check(g, "rec_doe", doe_o[g], a_we[g]);
        rd = mm[g][w[7:0]];
        if (a_vid[g]) begin
          e_vack = 1; e_vr[g] = rd;
        end else begin
          e_cack = 1;
          if (a_we[g]) begin
            if (ln) mm[g][w[7:0]][15:8] = a_dat[g];
            else    mm[g][w[7:0]][7:0]  = a_dat[g];
          end else begin
            e_cr[g] = ln ? rd[15:8] : rd[7:0];
          end
        end
        act[g] = 0;
      end
    end
    check(g, "wel", wel_o[g], e_wel);
    check(g, "lbl", lbl_o[g], e_lbl);
    check(g, "ubl", ubl_o[g], e_ubl);
    check(g, "cpu_ack", cpu_ack_o[g], e_cack);
    check(g, "vid_ack", vid_ack_o[g], e_vack);
    check(g, "cpu_rdata", cpu_rdata_o[g], e_cr[g]);
    check(g, "vid_rdata", vid_rdata_o[g], e_vr[g]);
    if (rst_n[g] && c >= free_at[g] && (cpu_req[g] || vid_req[g])) begin
      gv = vid_req[g] && (!cpu_req[g] || pref_vid[g]);
      act[g] = 1; a_t[g] = c; a_vid[g] = gv;
      a_we[g] = gv ? 1'b0 : cpu_we[g];
      a_addr[g] = gv ? {vid_addr[g], 1'b0} : cpu_addr[g];
      a_dat[g] = cpu_wdata[g];
      pref_vid[g] = !gv;
      free_at[g] = c + ws + 3;
    end
  endtask

  initial begin
    for (int g = 0; g < NCFG; g++)
      for (int i = 0; i < 256; i++) mm[g][i] = init_word(i);
    forever begin
      @(negedge clk);
      for (int g = 0; g < NCFG; g++) model_step(g);
    end
  end

  // Directed stimulus helpers
  int obs_wel_lo, obs_lanes_lo, obs_wr_ok, obs_cack;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int g, input bit vid, input int budget, output int at);
    obs_wel_lo = 0; obs_lanes_lo = 0; obs_wr_ok = 0; obs_cack = 0; at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!wel_o[g]) obs_wel_lo++;
      if (!lbl_o[g] && !ubl_o[g]) obs_lanes_lo++;
      if (!wel_o[g] && !ubl_o[g] && lbl_o[g] && sram_a_o[g] == 19'h00002) obs_wr_ok++;
      if (cpu_ack_o[g]) obs_cack++;
      if (vid ? vid_ack_o[g] : cpu_ack_o[g]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_chk++; n_fail++;
      $display("FAIL cfg%0d ack_timeout: got no ack within %0d cycles, required an ack", g, budget);
    end
  endtask

  task automatic cpu_op(input int g, input bit we, input logic [19:0] addr, input logic [7:0] d, output int lat);
    int t0, at;
    tick();
    cpu_req[g] = 1'b1; cpu_we[g] = we; cpu_addr[g] = addr; cpu_wdata[g] = d;
    t0 = cyc;
    wait_ack(g, 1'b0, 20, at);
    lat = (at < 0) ? -1 : at - t0;
    tick();
    cpu_req[g] = 1'b0;
  endtask

  task automatic vid_op(input int g, input logic [18:0] addr, output int lat);
    int t0, at;
    tick();
    vid_req[g] = 1'b1; vid_addr[g] = addr;
    t0 = cyc;
    wait_ack(g, 1'b1, 20, at);
    lat = (at < 0) ? -1 : at - t0;
    tick();
    vid_req[g] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required $finish");
    $fatal(1);
  end

  initial begin
    int lat, tr, at, acks;
    logic [3:0] ord [2];
    int         na  [2];
    int         ta  [2][4];

    rst_n = '0; cpu_req = '0; cpu_we = '0; vid_req = '0;
    cpu_addr = '0; cpu_wdata = '0; vid_addr = '0;

    // Requests toggling under reset must not disturb the pins.
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      cpu_req = {NCFG{i[0]}};
      vid_req = {NCFG{~i[0]}};
      @(negedge clk);
      check(0, "rst_hold_wel", wel_o[0], 1);
      check(0, "rst_hold_lanes", {lbl_o[0], ubl_o[0]}, 2'b11);
      check(0, "rst_hold_doe", doe_o[0], 0);
      check(0, "rst_hold_acks", {cpu_ack_o[0], vid_ack_o[0]}, 2'b00);
    end
    tick();
    cpu_req = '0; vid_req = '0;
    tick();
    rst_n = '1;
    repeat (3) tick();
    check(0, "idle_wel", wel_o[0], 1);
    check(0, "idle_lanes", {lbl_o[0], ubl_o[0]}, 2'b11);
    check(0, "idle_sram_a", sram_a_o[0], 0);

    // CPU write high byte of word 2, then read it back.
    cpu_op(0, 1'b1, 20'h00005, 8'hA5, lat);
    check(0, "wr_lat", lat, 3);
    check(0, "wr_wel_cycles", obs_wel_lo, 2);
    check(0, "wr_ub_only_a2", obs_wr_ok, 2);
    cpu_op(0, 1'b0, 20'h00005, 8'h00, lat);
    check(0, "rd_lat", lat, 3);
    check(0, "rd_data", cpu_rdata_o[0], 8'hA5);

    // Video word read.
    vid_op(0, 19'h01234, lat);
    check(0, "vid_lat", lat, 3);
    check(0, "vid_data", vid_rdata_o[0], 16'hBEEF);
    check(0, "vid_wel_cycles", obs_wel_lo, 0);
    check(0, "vid_lane_cycles", obs_lanes_lo, 2);
    check(0, "cpu_rdata_kept", cpu_rdata_o[0], 8'hA5);

    // Contention from reset on both VIDEO_FIRST settings.
    tick();
    rst_n[1:0] = 2'b00;
    cpu_req[1:0] = 2'b11; cpu_we[1:0] = 2'b00; vid_req[1:0] = 2'b11;
    cpu_addr[0] = 20'h00020; cpu_addr[1] = 20'h00021;
    vid_addr[0] = 19'h00040; vid_addr[1] = 19'h00041;
    tick();
    tick();
    rst_n[1:0] = 2'b11;
    tr = cyc;
    for (int g = 0; g < 2; g++) begin
      ord[g] = 4'b0000; na[g] = 0;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (cpu_ack_o[g] || vid_ack_o[g]) begin
          if (na[g] < 4) begin
            ord[g][3 - na[g]] = vid_ack_o[g];
            ta[g][na[g]] = cyc;
          end
          na[g]++;
        end
      end
    end
    tick();
    cpu_req[1:0] = 2'b00; vid_req[1:0] = 2'b00;
    for (int g = 0; g < 2; g++) begin
      check(g, "cont_ack_count", (na[g] >= 4) ? 1 : 0, 1);
      check(g, "cont_first_ack", ta[g][0] - tr, 3);
      for (int k = 0; k < 3; k++) check(g, "cont_spacing", ta[g][k + 1] - ta[g][k], 4);
    end
    check(0, "cont_order_vf1", ord[0], 4'b1010);
    check(1, "cont_order_vf0", ord[1], 4'b0101);
    repeat (6) tick();

    // Reset on the second ACCESS cycle of a CPU write; queued video request afterwards.
    tick();
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 20'h00040; cpu_wdata[0] = 8'h5A;
    vid_addr[0] = 19'h00077;
    tick();
    vid_req[0] = 1'b1;
    tick();
    check(0, "mid_wel_before", wel_o[0], 0);
    rst_n[0] = 1'b0;
    cpu_req[0] = 1'b0;
    #1;
    check(0, "mid_wel_async", wel_o[0], 1);
    check(0, "mid_lanes_async", {lbl_o[0], ubl_o[0]}, 2'b11);
    check(0, "mid_doe_async", doe_o[0], 0);
    @(negedge clk);
    check(0, "mid_no_ack", cpu_ack_o[0], 0);
    tick();
    rst_n[0] = 1'b1;
    tr = cyc;
    wait_ack(0, 1'b1, 10, at);
    check(0, "mid_vid_lat", (at < 0) ? -1 : at - tr, 3);
    check(0, "mid_no_cpu_ack", obs_cack, 0);
    check(0, "mid_vid_data", vid_rdata_o[0], 16'h2B77);
    tick();
    vid_req[0] = 1'b0;

    // Wait-state extremes.
    cpu_op(2, 1'b0, 20'h00007, 8'h00, lat);
    check(2, "ws0_lat", lat, 2);
    check(2, "ws0_data", cpu_rdata_o[2], 8'h5F);
    cpu_op(3, 1'b1, 20'h00011, 8'h3C, lat);
    check(3, "ws7_wr_lat", lat, 9);
    check(3, "ws7_wel_cycles", obs_wel_lo, 8);
    cpu_op(3, 1'b0, 20'h00011, 8'h00, lat);
    check(3, "ws7_rd_lat", lat, 9);
    check(3, "ws7_rd_data", cpu_rdata_o[3], 8'h3C);

    // Request dropped right after grant still completes with one ack.
    tick();
    cpu_req[2] = 1'b1; cpu_we[2] = 1'b0; cpu_addr[2] = 20'h00006;
    tick();
    cpu_req[2] = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpu_ack_o[2]) acks++;
    end
    check(2, "drop_ack_once", acks, 1);
    check(2, "drop_data", cpu_rdata_o[2], 8'h03);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
